// File: rtl/dma_copy_ctrl.sv
// dma_copy_ctrl: memory-mapped DMA engine that copies LEN 16-bit words
// from SRC to DST in the data RAM. It moves one word per cycle, and each
// RAM read feeds the write in the following cycle.
// Optional feature: define DMA_COPY_FILL_EN to add the FILL register at
// offset +4. With it, CTRL bit1 selects a constant-fill transfer.
module dma_copy_ctrl #(
   parameter logic [13:0] DMA_BASE = 14'h3FC0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dma_io_we,
   input  logic [15:2] dma_io_wadr,
   input  logic [31:0] dma_io_wdata,
   input  logic [15:2] dma_io_radr,
   input  logic        dma_io_radr_en,
   output logic [31:0] dma_io_rdata,
   output logic        dma_re_ma,
   output logic [15:2] dataram_radr_ma,
   input  logic [15:0] dataram_rdata_wb,
   output logic        dma_we_ma,
   output logic [15:2] dataram_wadr_ma,
   output logic [15:0] dataram_wdata_ma,
   output logic        dma_busy,
   output logic        dma_done_irq
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_STREAM = 1'b1;

   logic [0:0]  state;
   logic [13:0] src_r, dst_r, len_r;
   logic [13:0] dst_ptr;      // next write address in copy mode
   logic [13:0] rem;          // remaining reads (copy) or writes (fill)
   logic        done_r, aborted_r;
   logic        abort_pend;   // abort seen with one write still in flight
   logic        fill_mode;
   logic [15:0] fill_r;

   logic [13:0] woff, roff;
   logic        wr_src, wr_dst, wr_len, wr_ctrl, wr_fill;
   logic        start_req, abort_req, fill_req;
   logic        unused_wdata;

   assign woff      = dma_io_wadr - DMA_BASE;
   assign roff      = dma_io_radr - DMA_BASE;
   assign wr_src    = dma_io_we && (woff == 14'd0);
   assign wr_dst    = dma_io_we && (woff == 14'd1);
   assign wr_len    = dma_io_we && (woff == 14'd2);
   assign wr_ctrl   = dma_io_we && (woff == 14'd3);
   assign wr_fill   = dma_io_we && (woff == 14'd4);
   // Abort wins over start when both bits are written together.
   assign abort_req = wr_ctrl && dma_io_wdata[2];
   assign start_req = wr_ctrl && dma_io_wdata[0] && !dma_io_wdata[2];
   assign dma_busy  = (state == ST_STREAM);
   assign unused_wdata = ^{dma_io_wdata[31:14], dma_io_wdata[1]};

`ifdef DMA_COPY_FILL_EN
   assign fill_req = dma_io_wdata[1];
   assign dataram_wdata_ma = !dma_we_ma ? 16'd0 :
                             (fill_mode ? fill_r : dataram_rdata_wb);

   // FILL register, writable only while idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fill_r <= 16'd0;
      else if (!dma_busy && wr_fill)
         fill_r <= dma_io_wdata[15:0];
   end
`else
   assign fill_req = 1'b0;
   assign dataram_wdata_ma = dma_we_ma ? dataram_rdata_wb : 16'd0;

   // Fill feature absent: FILL stays zero and offset +4 writes are dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fill_r <= 16'd0;
      else if (wr_fill && 1'b0)
         fill_r <= dma_io_wdata[15:0];
   end
`endif

   // Software-visible SRC/DST/LEN, frozen while a transfer runs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_r <= 14'd0;
         dst_r <= 14'd0;
         len_r <= 14'd0;
      end else if (!dma_busy) begin
         if (wr_src) src_r <= dma_io_wdata[13:0];
         if (wr_dst) dst_r <= dma_io_wdata[13:0];
         if (wr_len) len_r <= dma_io_wdata[13:0];
      end
   end

   // Registered read port, holds its value between read requests
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         dma_io_rdata <= 32'd0;
      else if (dma_io_radr_en) begin
         case (roff)
            14'd0:   dma_io_rdata <= {18'd0, src_r};
            14'd1:   dma_io_rdata <= {18'd0, dst_r};
            14'd2:   dma_io_rdata <= {18'd0, len_r};
            14'd3:   dma_io_rdata <= {28'd0, aborted_r, done_r, 1'b0, dma_busy};
            14'd4:   dma_io_rdata <= {16'd0, fill_r};
            default: dma_io_rdata <= 32'd0;
         endcase
      end
   end

   // Transfer FSM: registered RAM strobes and addresses, status and irq
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= ST_IDLE;
         dma_re_ma       <= 1'b0;
         dma_we_ma       <= 1'b0;
         dataram_radr_ma <= 14'd0;
         dataram_wadr_ma <= 14'd0;
         dst_ptr         <= 14'd0;
         rem             <= 14'd0;
         done_r          <= 1'b0;
         aborted_r       <= 1'b0;
         abort_pend      <= 1'b0;
         fill_mode       <= 1'b0;
         dma_done_irq    <= 1'b0;
      end else begin
         dma_done_irq <= 1'b0;
         if (state == ST_IDLE) begin
            if (start_req) begin
               aborted_r <= 1'b0;
               if (len_r == 14'd0) begin
                  done_r       <= 1'b1;
                  dma_done_irq <= 1'b1;
               end else begin
                  state      <= ST_STREAM;
                  done_r     <= 1'b0;
                  abort_pend <= 1'b0;
                  rem        <= len_r;
                  fill_mode  <= fill_req;
                  if (fill_req) begin
                     dma_we_ma       <= 1'b1;
                     dataram_wadr_ma <= dst_r;
                     dst_ptr         <= dst_r + 14'd1;
                  end else begin
                     dma_re_ma       <= 1'b1;
                     dataram_radr_ma <= src_r;
                     dst_ptr         <= dst_r;
                  end
               end
            end
         end else if (abort_req || abort_pend) begin
            // Stop reading at once; let an outstanding read land as one write
            dma_re_ma <= 1'b0;
            if (abort_req && dma_re_ma) begin
               dma_we_ma       <= 1'b1;
               dataram_wadr_ma <= dst_ptr;
               abort_pend      <= 1'b1;
            end else begin
               dma_we_ma  <= 1'b0;
               state      <= ST_IDLE;
               aborted_r  <= 1'b1;
               abort_pend <= 1'b0;
            end
         end else if (fill_mode) begin
            if (rem > 14'd1) begin
               dataram_wadr_ma <= dst_ptr;
               dst_ptr         <= dst_ptr + 14'd1;
               rem             <= rem - 14'd1;
            end else begin
               dma_we_ma    <= 1'b0;
               state        <= ST_IDLE;
               done_r       <= 1'b1;
               dma_done_irq <= 1'b1;
            end
         end else if (dma_re_ma) begin
            // Each read becomes a write next cycle
            dma_we_ma       <= 1'b1;
            dataram_wadr_ma <= dst_ptr;
            dst_ptr         <= dst_ptr + 14'd1;
            if (rem > 14'd1) begin
               dataram_radr_ma <= dataram_radr_ma + 14'd1;
               rem             <= rem - 14'd1;
            end else begin
               dma_re_ma <= 1'b0;
            end
         end else begin
            // Last write is on the bus this cycle
            dma_we_ma    <= 1'b0;
            state        <= ST_IDLE;
            done_r       <= 1'b1;
            dma_done_irq <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dma_copy_ctrl.sv
// Self-checking bench for dma_copy_ctrl: a scoreboard of expected RAM
// reads/writes (address, data, cycle) is consumed by a bus monitor.
// The fill scenario follows DMA_COPY_FILL_EN.
module tb_dma_copy_ctrl;

   localparam logic [13:0] BASE = 14'h3FC0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dma_io_we = 1'b0;
   logic [13:0] dma_io_wadr = 14'd0;
   logic [31:0] dma_io_wdata = 32'd0;
   logic [13:0] dma_io_radr = 14'd0;
   logic        dma_io_radr_en = 1'b0;
   logic [31:0] dma_io_rdata;
   logic        dma_re_ma;
   logic [13:0] dataram_radr_ma;
   logic [15:0] dataram_rdata_wb;
   logic        dma_we_ma;
   logic [13:0] dataram_wadr_ma;
   logic [15:0] dataram_wdata_ma;
   logic        dma_busy;
   logic        dma_done_irq;

   dma_copy_ctrl #(.DMA_BASE(BASE)) dut (
      .clk(clk), .rst(rst),
      .dma_io_we(dma_io_we), .dma_io_wadr(dma_io_wadr), .dma_io_wdata(dma_io_wdata),
      .dma_io_radr(dma_io_radr), .dma_io_radr_en(dma_io_radr_en), .dma_io_rdata(dma_io_rdata),
      .dma_re_ma(dma_re_ma), .dataram_radr_ma(dataram_radr_ma), .dataram_rdata_wb(dataram_rdata_wb),
      .dma_we_ma(dma_we_ma), .dataram_wadr_ma(dataram_wadr_ma), .dataram_wdata_ma(dataram_wdata_ma),
      .dma_busy(dma_busy), .dma_done_irq(dma_done_irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          c;
      logic [13:0] a;
      logic [15:0] d;
   } exp_t;

   exp_t rd_q[$];
   exp_t wr_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   irq_cnt = 0;
   int   irq_cyc = -1;
   int   busy_cnt = 0;
   logic [15:0] ram_q = 16'd0;

   // Data RAM model: contents are a fixed function of the address
   function automatic logic [15:0] ram_f(input logic [13:0] a);
      return {a[1:0], a} ^ 16'h5A3C;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (dma_re_ma) ram_q <= ram_f(dataram_radr_ma);
   assign dataram_rdata_wb = ram_q;

   // Bus monitor: pops the scoreboard on every RAM access
   always @(negedge clk) begin
      exp_t e;
      if (dma_busy) busy_cnt++;
      if (dma_done_irq) begin irq_cnt++; irq_cyc = cyc; end
      if (dma_re_ma) begin
         checks++;
         if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected got addr=%h cyc=%0d want no read", dataram_radr_ma, cyc);
         end else begin
            e = rd_q.pop_front();
            if (dataram_radr_ma !== e.a || cyc != e.c) begin
               errors++;
               $display("FAIL rd_access got addr=%h cyc=%0d want addr=%h cyc=%0d", dataram_radr_ma, cyc, e.a, e.c);
            end
         end
      end
      if (dma_we_ma) begin
         checks++;
         if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected got addr=%h data=%h cyc=%0d want no write", dataram_wadr_ma, dataram_wdata_ma, cyc);
         end else begin
            e = wr_q.pop_front();
            if (dataram_wadr_ma !== e.a || dataram_wdata_ma !== e.d || cyc != e.c) begin
               errors++;
               $display("FAIL wr_access got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                        dataram_wadr_ma, dataram_wdata_ma, cyc, e.a, e.d, e.c);
            end
         end
      end
   end

   task automatic cpu_write(input int off, input logic [31:0] d);
      dma_io_we = 1'b1; dma_io_wadr = BASE + 14'(off); dma_io_wdata = d;
      @(posedge clk); #1;
      dma_io_we = 1'b0;
   endtask

   task automatic cpu_read(input int off, output logic [31:0] d);
      dma_io_radr_en = 1'b1; dma_io_radr = BASE + 14'(off);
      @(posedge clk); #1;
      dma_io_radr_en = 1'b0;
      d = dma_io_rdata;
   endtask

   task automatic clear_mon();
      irq_cnt = 0; irq_cyc = -1; busy_cnt = 0;
   endtask

   task automatic push_copy(input logic [13:0] src, input logic [13:0] dst, input int n, input int t0);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.c = t0 + k;     e.a = src + 14'(k); e.d = 16'd0;
         rd_q.push_back(e);
         e.c = t0 + k + 1; e.a = dst + 14'(k); e.d = ram_f(src + 14'(k));
         wr_q.push_back(e);
      end
   endtask

   task automatic check_sb(input string name);
      checks++;
      if (rd_q.size() != 0 || wr_q.size() != 0) begin
         errors++;
         $display("FAIL %s_pending got rd=%0d wr=%0d want 0 0", name, rd_q.size(), wr_q.size());
         rd_q.delete(); wr_q.delete();
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({dma_re_ma, dma_we_ma, dma_busy, dma_done_irq} !== 4'b0 || dma_io_rdata !== 32'd0 ||
          dataram_radr_ma !== 14'd0 || dataram_wadr_ma !== 14'd0 || dataram_wdata_ma !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs got re=%b we=%b busy=%b irq=%b rdata=%h want all 0",
                  dma_re_ma, dma_we_ma, dma_busy, dma_done_irq, dma_io_rdata);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      for (int off = 0; off < 6; off++) begin
         cpu_read(off, d);
         checks++;
         if (d !== 32'd0) begin errors++; $display("FAIL reset_reg%0d got %h want 0", off, d); end
      end
   endtask

   task automatic test_copy();
      logic [31:0] d;
      int t0;
      cpu_write(0, 32'h10); cpu_write(1, 32'h80); cpu_write(2, 32'h4);
      clear_mon();
      cpu_write(3, 32'h1);
      t0 = cyc;
      push_copy(14'h10, 14'h80, 4, t0);
      cpu_write(0, 32'h55);             // dropped: engine is busy
      repeat (8) @(posedge clk);
      #1;
      check_sb("copy");
      checks++;
      if (irq_cnt != 1 || irq_cyc != t0 + 5) begin
         errors++; $display("FAIL copy_irq got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", irq_cnt, irq_cyc, t0 + 5);
      end
      checks++;
      if (busy_cnt != 5) begin errors++; $display("FAIL copy_busy got %0d want 5", busy_cnt); end
      cpu_read(3, d);
      checks++;
      if (d !== 32'h4) begin errors++; $display("FAIL copy_status got %h want 4", d); end
      cpu_read(0, d);
      checks++;
      if (d !== 32'h10) begin errors++; $display("FAIL copy_src_hold got %h want 10", d); end
   endtask

   task automatic test_wrap();
      logic [31:0] d;
      int t0;
      cpu_write(0, 32'h3FFE); cpu_write(1, 32'h3FFF); cpu_write(2, 32'h3);
      clear_mon();
      cpu_write(3, 32'h1);
      t0 = cyc;
      push_copy(14'h3FFE, 14'h3FFF, 3, t0);
      repeat (7) @(posedge clk);
      #1;
      check_sb("wrap");
      checks++;
      if (irq_cnt != 1 || irq_cyc != t0 + 4) begin
         errors++; $display("FAIL wrap_irq got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", irq_cnt, irq_cyc, t0 + 4);
      end
      cpu_read(3, d);
      checks++;
      if (d !== 32'h4) begin errors++; $display("FAIL wrap_status got %h want 4", d); end
   endtask

   task automatic test_abort();
      logic [31:0] d;
      int t0;
      cpu_write(0, 32'h200); cpu_write(1, 32'h300); cpu_write(2, 32'h8);
      clear_mon();
      cpu_write(3, 32'h1);
      t0 = cyc;
      push_copy(14'h200, 14'h300, 4, t0);
      repeat (3) @(posedge clk);
      #1;
      cpu_write(3, 32'h5);              // start+abort acts as abort
      repeat (10) @(posedge clk);
      #1;
      check_sb("abort");
      checks++;
      if (irq_cnt != 0) begin errors++; $display("FAIL abort_irq got %0d want 0", irq_cnt); end
      checks++;
      if (busy_cnt != 5) begin errors++; $display("FAIL abort_busy got %0d want 5", busy_cnt); end
      cpu_read(3, d);
      checks++;
      if (d !== 32'h8) begin errors++; $display("FAIL abort_status got %h want 8", d); end
   endtask

   task automatic test_len0();
      logic [31:0] d;
      int t0;
      cpu_write(2, 32'h0);
      clear_mon();
      cpu_write(3, 32'h1);
      t0 = cyc;
      repeat (4) @(posedge clk);
      #1;
      check_sb("len0");
      checks++;
      if (irq_cnt != 1 || irq_cyc != t0) begin
         errors++; $display("FAIL len0_irq got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", irq_cnt, irq_cyc, t0);
      end
      checks++;
      if (busy_cnt != 0) begin errors++; $display("FAIL len0_busy got %0d want 0", busy_cnt); end
      cpu_read(3, d);
      checks++;
      if (d !== 32'h4) begin errors++; $display("FAIL len0_status got %h want 4", d); end
   endtask

   task automatic test_rst_mid();
      logic [31:0] d;
      int t0;
      exp_t e;
      cpu_write(0, 32'h40); cpu_write(1, 32'h50); cpu_write(2, 32'h6);
      clear_mon();
      cpu_write(3, 32'h1);
      t0 = cyc;
      for (int k = 0; k < 2; k++) begin
         e.c = t0 + k; e.a = 14'h40 + 14'(k); e.d = 16'd0;
         rd_q.push_back(e);
      end
      e.c = t0 + 1; e.a = 14'h50; e.d = ram_f(14'h40);
      wr_q.push_back(e);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({dma_re_ma, dma_we_ma, dma_busy, dma_done_irq} !== 4'b0 || dma_io_rdata !== 32'd0 ||
          dataram_radr_ma !== 14'd0 || dataram_wadr_ma !== 14'd0 || dataram_wdata_ma !== 16'd0) begin
         errors++;
         $display("FAIL rstmid_outputs got re=%b we=%b busy=%b radr=%h wadr=%h rdata=%h want all 0",
                  dma_re_ma, dma_we_ma, dma_busy, dataram_radr_ma, dataram_wadr_ma, dma_io_rdata);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check_sb("rstmid");
      checks++;
      if (irq_cnt != 0) begin errors++; $display("FAIL rstmid_irq got %0d want 0", irq_cnt); end
      cpu_read(3, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL rstmid_status got %h want 0", d); end
      cpu_read(2, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL rstmid_len got %h want 0", d); end
   endtask

   task automatic test_fill();
      logic [31:0] d;
      int t0;
      exp_t e;
      cpu_write(4, 32'hA5A5); cpu_write(0, 32'h30); cpu_write(1, 32'h20); cpu_write(2, 32'h3);
      cpu_write(5, 32'h1234);           // unmapped offset
      cpu_read(5, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h want 0", d); end
      cpu_read(4, d);
      checks++;
`ifdef DMA_COPY_FILL_EN
      if (d !== 32'hA5A5) begin errors++; $display("FAIL fill_reg got %h want a5a5", d); end
`else
      if (d !== 32'h0) begin errors++; $display("FAIL fill_reg got %h want 0", d); end
`endif
      clear_mon();
      cpu_write(3, 32'h3);              // start with fill bit
      t0 = cyc;
`ifdef DMA_COPY_FILL_EN
      for (int k = 0; k < 3; k++) begin
         e.c = t0 + k; e.a = 14'h20 + 14'(k); e.d = 16'hA5A5;
         wr_q.push_back(e);
      end
`else
      push_copy(14'h30, 14'h20, 3, t0);
      e.c = 0; e.a = 14'd0; e.d = 16'd0;
`endif
      repeat (7) @(posedge clk);
      #1;
      check_sb("fill");
      checks++;
`ifdef DMA_COPY_FILL_EN
      if (irq_cnt != 1 || irq_cyc != t0 + 3 || busy_cnt != 3) begin
         errors++; $display("FAIL fill_done got irq=%0d cyc=%0d busy=%0d want 1 %0d 3", irq_cnt, irq_cyc, busy_cnt, t0 + 3);
      end
`else
      if (irq_cnt != 1 || irq_cyc != t0 + 4 || busy_cnt != 4) begin
         errors++; $display("FAIL fill_done got irq=%0d cyc=%0d busy=%0d want 1 %0d 4", irq_cnt, irq_cyc, busy_cnt, t0 + 4);
      end
`endif
      cpu_read(3, d);
      checks++;
      if (d !== 32'h4) begin errors++; $display("FAIL fill_status got %h want 4", d); end
   endtask

   initial begin
      test_reset();
      test_copy();
      test_wrap();
      test_abort();
      test_len0();
      test_rst_mid();
      test_fill();
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
